// File: rtl/elevator_io_pkg.sv
// Shared front-panel I/O definitions: matrix geometry, key-code width, scan FSM states.
package elevator_io_pkg;

    localparam int unsigned N_COL    = 4;
    localparam int unsigned N_ROW    = 4;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned CALL_W   = N_COL * N_ROW;
    localparam int unsigned DB_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; second stage is the only one safe to use downstream.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/call_keypad_scanner.sv
// 4x4 call-button matrix scanner: column drive, debounce, key code and pending-call bitmap.
module call_keypad_scanner #(
    parameter int unsigned CLK_DIV  = 6000,
    parameter int unsigned N_COL    = elevator_io_pkg::N_COL,
    parameter int unsigned N_ROW    = elevator_io_pkg::N_ROW,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                           clk,
    input  logic                           resetn,
    output logic [N_COL-1:0]               key_col,
    input  logic [N_ROW-1:0]               key_row,
    output logic [elevator_io_pkg::KEY_W-1:0] key_code,
    output logic                           key_valid,
    output logic                           key_held,
    output logic [N_COL*N_ROW-1:0]         call_req,
    input  logic [N_COL*N_ROW-1:0]         call_clr
);

    import elevator_io_pkg::*;

    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned COL_W   = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned KEYS    = N_COL * N_ROW;
    localparam logic [DB_CNT_W-1:0] DB_N = DB_CNT_W'(DEBOUNCE);

    logic [PRESC_W-1:0]  presc_q;
    logic                scan_tick;
    logic [N_ROW-1:0]    row_sync;
    logic [COL_W-1:0]    col_idx_q;
    logic                last_col;
    logic                frame_end;
    logic [KEYS-1:0]     snap_q;
    logic [KEYS-1:0]     frame_c;
    logic [1:0]          n_down;
    logic [KEY_W-1:0]    frame_code;
    logic                single;
    logic                match;
    scan_state_t         state_q;
    scan_state_t         state_d;
    logic [KEY_W-1:0]    cand_q;
    logic [KEY_W-1:0]    cand_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;
    logic [DB_CNT_W-1:0] cnt_inc;
    logic                accept_c;
    logic                held_c;

    assign scan_tick = (presc_q == PRESC_W'(CLK_DIV - 1));
    assign last_col  = (col_idx_q == COL_W'(N_COL - 1));
    assign frame_end = scan_tick && last_col;
    assign match     = single && (frame_code == cand_q);
    assign cnt_inc   = cnt_q + DB_CNT_W'(1);

    // Column-step prescaler.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
        end else if (scan_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    sync2 #(.W(N_ROW)) u_row_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (key_row),
        .q      (row_sync)
    );

    // Advance the driven column on each scan tick, wrapping after the last one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_idx_q <= '0;
            key_col   <= N_COL'(1);
        end else if (scan_tick) begin
            if (last_col) begin
                col_idx_q <= '0;
                key_col   <= N_COL'(1);
            end else begin
                col_idx_q <= col_idx_q + COL_W'(1);
                key_col   <= key_col << 1;
            end
        end
    end

    // Store the rows seen for the driven column into the frame snapshot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            snap_q <= '0;
        end else begin
            for (int c = 0; c < N_COL; c++) begin
                if (scan_tick && (col_idx_q == COL_W'(c))) begin
                    snap_q[c*N_ROW +: N_ROW] <= row_sync;
                end
            end
        end
    end

    // Classify the completed frame; the last column comes straight from the synchronizer.
    always_comb begin
        frame_c = snap_q;
        frame_c[(N_COL-1)*N_ROW +: N_ROW] = row_sync;
        n_down     = 2'd0;
        frame_code = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (frame_c[i]) begin
                if (n_down != 2'd2) begin
                    n_down = n_down + 2'd1;
                end
                frame_code = KEY_W'(i);
            end
        end
        single = (n_down == 2'd1);
    end

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan FSM next state, evaluated only when a frame completes.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (single) begin
                        cand_d = frame_code;
                        if (DB_N == DB_CNT_W'(1)) begin
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = DB_CNT_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (match) begin
                        if (cnt_inc == DB_N) begin
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!match) begin
                        if (DB_N == DB_CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = DB_CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (match) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == DB_N) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Scan FSM outputs: accept only on entry to PRESSED from the press side.
    always_comb begin
        accept_c = ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE)) && (state_d == ST_PRESSED);
        held_c   = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    // Registered key outputs and pending-call bitmap; a same-cycle accept beats a clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            call_req  <= '0;
        end else begin
            key_valid <= accept_c;
            key_held  <= held_c;
            if (accept_c) begin
                key_code <= cand_d;
            end
            for (int i = 0; i < KEYS; i++) begin
                if (accept_c && (cand_d == KEY_W'(i))) begin
                    call_req[i] <= 1'b1;
                end else if (call_clr[i]) begin
                    call_req[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_call_keypad_scanner.sv
// Scoreboard bench for call_keypad_scanner with a frame-level key-matrix model.
module tb_call_keypad_scanner;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] call_req;
    logic [15:0] call_clr;
    logic [15:0] keys;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    typedef struct {
        logic [3:0] code;
        longint     cyc;
    } exp_t;
    exp_t sb_q[$];

    // Reference state, one update per scan frame.
    int          m_phase;   // 0 idle, 1 debouncing, 2 pressed, 3 releasing
    int          m_cnt;
    int          m_cand;
    logic [15:0] m_bitmap;

    call_keypad_scanner #(
        .CLK_DIV  (4),
        .N_COL    (4),
        .N_ROW    (4),
        .DEBOUNCE (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .call_req  (call_req),
        .call_clr  (call_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical switch matrix: a pressed key connects its column drive to its row.
    always_comb begin
        key_row = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (key_col[c] && keys[c*4 + r]) key_row[r] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level debounce rules: a press needs 3 identical single-key frames, a release 3 non-matching frames.
    task automatic model_frame(input logic [15:0] k, output logic acc, output logic [3:0] code);
        int  n;
        int  c;
        logic single;
        n = $countones(k);
        c = 0;
        for (int i = 0; i < 16; i++) if (k[i]) c = i;
        single = (n == 1);
        acc  = 1'b0;
        code = 4'(c);
        case (m_phase)
            0: if (single) begin m_cand = c; m_phase = 1; m_cnt = 1; end
            1: begin
                if (single && c == m_cand) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 3) begin m_phase = 2; m_cnt = 0; acc = 1'b1; end
                end else begin
                    m_phase = 0; m_cnt = 0;
                end
            end
            2: if (!(single && c == m_cand)) begin m_phase = 3; m_cnt = 1; end
            default: begin
                if (single && c == m_cand) begin
                    m_phase = 2; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 3) begin m_phase = 0; m_cnt = 0; end
                end
            end
        endcase
        code = 4'(m_cand);
    endtask

    // Apply one frame of key state; clr_mid lands mid-frame, clr_end in the frame-end cycle.
    task automatic run_frame(input logic [15:0] k, input logic [15:0] clr_mid, input logic [15:0] clr_end);
        logic       acc;
        logic [3:0] code;
        keys = k;
        check("key_col_frame_start", 64'(key_col), 64'(4'b0001));
        check("key_held", 64'(key_held), 64'((m_phase == 2) || (m_phase == 3)));
        check("call_req", 64'(call_req), 64'(m_bitmap));
        model_frame(k, acc, code);
        if (acc) sb_q.push_back('{code, cyc + 16});
        repeat (5) @(negedge clk);
        call_clr = clr_mid;
        m_bitmap = m_bitmap & ~clr_mid;
        @(negedge clk);
        call_clr = '0;
        if (clr_mid != 16'd0) check("call_req_after_clear", 64'(call_req), 64'(m_bitmap));
        repeat (9) @(negedge clk);
        call_clr = clr_end;
        @(negedge clk);
        call_clr = '0;
        if (acc) m_bitmap = (m_bitmap & ~clr_end) | (16'd1 << code);
        else     m_bitmap = m_bitmap & ~clr_end;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_key_col", 64'(key_col), 64'(4'b0001));
        check("rst_key_valid", 64'(key_valid), 64'd0);
        check("rst_key_held", 64'(key_held), 64'd0);
        check("rst_key_code", 64'(key_code), 64'd0);
        check("rst_call_req", 64'(call_req), 64'd0);
        m_phase  = 0;
        m_cnt    = 0;
        m_cand   = 0;
        m_bitmap = '0;
        resetn   = 1'b1;
    endtask

    // Monitor: every key_valid pulse must match the oldest expected accept.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (key_valid) begin
            check("valid_not_back_to_back", 64'(prev_valid), 64'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_key_valid actual=code %0d required=no pulse at cycle %0d", key_code, cyc);
            end else begin
                e = sb_q.pop_front();
                check("valid_key_code", 64'(key_code), 64'(e.code));
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
                check("valid_call_req_bit", 64'(call_req[e.code]), 64'd1);
                check("valid_key_held", 64'(key_held), 64'd1);
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K7  = 16'h0080;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] KGH = 16'h8001;

    initial begin
        logic [15:0] k;
        logic [15:0] prev_single;
        logic [15:0] cm;
        logic [15:0] ce;
        int          r;
        int          a;
        int          b;

        keys     = '0;
        call_clr = '0;
        resetn   = 1'b0;

        // Reset release and column stepping.
        do_reset(5);
        repeat (3) @(negedge clk);
        check("key_col_before_step", 64'(key_col), 64'(4'b0001));
        @(negedge clk);
        check("key_col_step", 64'(key_col), 64'(4'b0010));
        repeat (12) @(negedge clk);
        check("key_col_wrap", 64'(key_col), 64'(4'b0001));

        // Clean press of col2/row1 then release.
        repeat (5) run_frame(K9, '0, '0);
        repeat (4) run_frame('0, '0, '0);

        // Controller clears the served call.
        run_frame('0, K9, '0);

        // Bounce on col1/row3.
        run_frame(K7, '0, '0);
        run_frame('0, '0, '0);
        run_frame(K7, '0, '0);
        repeat (3) run_frame('0, '0, '0);

        // Ghosting: two keys in different rows and columns.
        repeat (5) run_frame(KGH, '0, '0);
        repeat (2) run_frame('0, '0, '0);

        // Accept and clear of the same bit in the same cycle.
        run_frame(K9, '0, '0);
        run_frame(K9, '0, '0);
        run_frame(K9, '0, K9);
        repeat (4) run_frame('0, '0, '0);

        // Reset in the middle of the second qualifying frame of key 5.
        run_frame(K5, '0, '0);
        keys = K5;
        repeat (8) @(negedge clk);
        do_reset(3);
        repeat (3) run_frame(K5, '0, '0);
        repeat (4) run_frame('0, '0, '0);

        // Randomized key activity with random controller clears.
        prev_single = 16'h0001;
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                k = '0;
            end else if (r < 7) begin
                k = prev_single;
            end else if (r < 9) begin
                k = 16'd1 << $urandom_range(0, 15);
                prev_single = k;
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                k = (16'd1 << a) | (16'd1 << b);
            end
            cm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
            ce = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
            run_frame(k, cm, ce);
        end
        repeat (4) run_frame('0, '0, '0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_keypad_scanner.md
Name: call_keypad_scanner

Overview:
- Reads a 4x4 call-button matrix on the front panel. The display driver writes the LED matrix; this block is its read-side counterpart.
- Drives one key column at a time and samples the key rows. It debounces a single pressed key and reports it as a 4-bit key code.
- It also latches each accepted key into a pending-call bitmap. The elevator controller reads the bitmap and clears individual bits once a call is served.

Parameters:
- CLK_DIV, 6000, system clocks per column step; must be >= 3.
- N_COL, 4, number of matrix columns.
- N_ROW, 4, number of matrix rows.
- DEBOUNCE, 3, consecutive identical frames needed to accept a press or a release; range 1..15.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- key_col  out  N_COL  one-hot column drive, active-high.
- key_row  in  N_ROW  raw row sense, active-high, asynchronous to clk.
- key_code  out  4  code of the last accepted key: col*N_ROW + row.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high while the accepted key is still down.
- call_req  out  N_COL*N_ROW  pending-call bitmap.
- call_clr  in  N_COL*N_ROW  per-bit clear strobes from the controller.

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values:
  - key_col = one-hot column 0 (0001).
  - key_code = 0, key_valid = 0, key_held = 0, call_req = 0.
  - Prescaler = 0, column index = 0, FSM = IDLE.
  - Frame snapshot and debounce counter cleared.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - scan_tick is high for one cycle when count == CLK_DIV-1.
- Row input path:
  - key_row passes through a 2-flop synchronizer.
  - The synchronized value is sampled on scan_tick, for the column currently driven.
  - After sampling, the column index advances and wraps from N_COL-1 to 0. key_col updates in the same cycle.
- Frame:
  - One frame is N_COL scan_ticks.
  - The frame ends on the scan_tick taken while column N_COL-1 is driven.
- Frame classification:
  - Exactly one key down → SINGLE(code).
  - Zero keys down → NONE.
  - Two or more keys down → NONE (ghosting rejection).
- FSM, evaluated only at frame end:
  - IDLE:
    - SINGLE(c) → DEBOUNCE; cand = c, cnt = 1.
    - If DEBOUNCE == 1, go directly to PRESSED instead, with the accept actions below.
  - DEBOUNCE:
    - SINGLE(cand) → cnt++.
    - When cnt reaches DEBOUNCE → PRESSED and accept: key_code = cand, key_valid pulses, call_req[cand] is set.
    - Any other classification → IDLE; cnt = 0.
  - PRESSED (key_held = 1):
    - NONE, or SINGLE with a different code → RELEASE; cnt = 1.
    - SINGLE(cand) → stay in PRESSED.
  - RELEASE (key_held = 1):
    - NONE or a different code → cnt++; when cnt reaches DEBOUNCE → IDLE.
    - SINGLE(cand) → PRESSED; no new key_valid.
- Latency: key_valid is asserted in the cycle after the scan_tick that ends the DEBOUNCE-th consecutive qualifying frame.
- key_valid is never high for two consecutive cycles.
- call_req, per bit, each cycle:
  - Accept of code i → bit i set.
  - Otherwise call_clr[i] = 1 → bit i cleared.
  - When accept and clear hit the same bit in the same cycle, set wins.
  - Clearing a bit never disturbs the other bits.
- Reset mid-operation returns every register to its reset value on the next clock edge. A pending candidate or held key is discarded with no key_valid pulse.
- Codes are unsigned, 4 bits wide. The code arithmetic is col*N_ROW + row, with no overflow for the default 4x4 matrix.

Decomposition:
- Shared package elevator_io_pkg:
  - N_COL, N_ROW, key-code width.
  - Scan FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - Call-bitmap width, shared with the controller and the dot-matrix driver.
- One sub-module is natural: sync2, a generic 2-flop synchronizer, parameterised by width and used on key_row.

Test Plan (bench uses CLK_DIV=4, DEBOUNCE=3, 4x4 matrix; one frame = 16 cycles):
- Reset release: hold resetn=0 for 5 cycles → key_col=0001, call_req=0, key_valid=0; key_col steps 0010 after 4 cycles, wraps to 0001 after 16.
- Clean press: model a key at col2/row1 held for 5 frames → exactly one key_valid pulse; key_code=9, call_req=0x0200; key_held=1 until 3 NONE frames after release.
- Bounce rejection: key col1/row3 down for 1 frame, up 1 frame, down 1 frame → no key_valid; call_req unchanged.
- Ghosting: keys col0/row0 and col3/row3 held together for 5 frames → no key_valid; state stays IDLE.
- Clear vs set: call_req[9]=1; pulse call_clr=0x0200 → bit drops the next cycle. Repeat with call_clr[9] in the same cycle as an accept of code 9 → call_req[9] stays 1.
- Reset mid-debounce: assert resetn=0 during the 2nd qualifying frame of key 5 → all outputs at reset values, no key_valid. After release, 3 full frames are needed again for the pulse.
